// File: rtl/zekgn_pkg.sv
// Shared types for the zekgn frame packer: row/frame layout, FSM states and sizes.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package zekgn_pkg;

    localparam int ROWS  = 3;
    localparam int TAG_W = 4;

    // One 8-bit row. Flattened MSB first: bit7 lands in [3][3], bit0 in [0][4].
    typedef logic [3:0][3:4] row_t;

    // Whole frame. Row 3 is filled first, row 1 last.
    typedef row_t [3:1][3:3] frame_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Place a stream byte into a row using the packed MSB-first flattening.
    function automatic row_t byte_to_row(input logic [7:0] b);
        return row_t'(b);
    endfunction

endpackage

// File: rtl/zekgn_row_parity.sv
// Even-parity (XOR reduction) of one frame row.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
//
// Ports:
//   row    : row value to reduce
//   parity : XOR of all 8 row bits (1 when the row has an odd number of ones)
module zekgn_row_parity
    import zekgn_pkg::*;
(
    input  row_t row,
    output logic parity
);

    assign parity = ^row;

endmodule

// File: rtl/zekgn_frame_packer.sv
// Packs a valid/ready byte stream (with last marker) into 3-row frames plus a 4-bit tag.
// Latency: frame valid the cycle after its last accepted byte; peak one frame per 4 cycles.
// Backpressure: s_ready drops while a frame is held; frame and tag hold until m_valid && m_ready.
//
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   s_data/s_valid/s_last   : input byte stream, s_ready accepts a byte
//   zekgn[3:1][3:3]         : frame rows, row 3 carries the first byte
//   jtqlupj                 : frame tag
//   m_valid/m_ready         : frame handshake
//   frames_sent             : count of delivered frames, wraps in two's complement
//
// Build option ZEKGN_PARITY_TAG_EN: tag becomes {parity row3, row2, row1, short-frame flag}
// instead of the sequence number.
module zekgn_frame_packer
    import zekgn_pkg::*;
#(
    parameter logic [7:0]       PAD_BYTE = 8'h00,
    parameter logic [TAG_W-1:0] TAG_INIT = 4'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [3:0][3:4]    zekgn [3:1][3:3],
    output logic [TAG_W-1:0]   jtqlupj,
    output logic               m_valid,
    input  logic               m_ready,
    output logic signed [31:0] frames_sent
);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    frame_t      frame_q, frame_d;
    logic [31:0] cnt_q, cnt_d;
    logic        s_ready_q;

    logic        accept;     // byte taken this cycle
    logic        fin;        // this byte completes the frame
    logic        hs;         // frame delivered this cycle

    assign accept = (state_q == FILL) && s_ready_q && s_valid;
    assign fin    = accept && ((idx_q == 2'd2) || s_last);
    assign hs     = (state_q == HOLD) && m_ready;

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    // Current byte goes to row 3-idx; on an early last, every
                    // row after it is padded so the frame never carries stale bytes.
                    case (idx_q)
                        2'd0: begin
                            frame_d[3][3] = byte_to_row(s_data);
                            if (s_last) begin
                                frame_d[2][3] = byte_to_row(PAD_BYTE);
                                frame_d[1][3] = byte_to_row(PAD_BYTE);
                            end
                        end
                        2'd1: begin
                            frame_d[2][3] = byte_to_row(s_data);
                            if (s_last) begin
                                frame_d[1][3] = byte_to_row(PAD_BYTE);
                            end
                        end
                        2'd2: begin
                            frame_d[1][3] = byte_to_row(s_data);
                        end
                        default: begin
                            frame_d = frame_q;
                        end
                    endcase

                    if (fin) begin
                        state_d = HOLD;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            HOLD: begin
                if (hs) begin
                    state_d = FILL;
                    idx_d   = 2'd0;
                    cnt_d   = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = FILL;
                idx_d   = 2'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FILL;
            idx_q     <= 2'd0;
            frame_q   <= '0;
            cnt_q     <= 32'd0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            cnt_q     <= cnt_d;
            // Registered so it reads 0 in the cycle right after a reset edge.
            s_ready_q <= (state_d == FILL);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_ready     = s_ready_q;
    assign m_valid     = (state_q == HOLD);
    assign frames_sent = cnt_q;

    for (genvar r = 1; r <= ROWS; r++) begin : g_rows
        assign zekgn[r][3] = frame_q[r][3];
    end

`ifdef ZEKGN_PARITY_TAG_EN
    logic       short_q;
    logic [3:1] row_par;

    // Remember whether the frame ended before its third byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            short_q <= 1'b0;
        end else if (fin) begin
            short_q <= (idx_q != 2'd2);
        end
    end

    for (genvar r = 1; r <= ROWS; r++) begin : g_par
        zekgn_row_parity u_par (
            .row    (frame_q[r][3]),
            .parity (row_par[r])
        );
    end

    assign jtqlupj = {row_par[3], row_par[2], row_par[1], short_q};
`else
    logic [TAG_W-1:0] seq_q;

    // Sequence tag advances per delivered frame and wraps 15 -> 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq_q <= TAG_INIT;
        end else if (hs) begin
            seq_q <= seq_q + 1'b1;
        end
    end

    assign jtqlupj = seq_q;
`endif

endmodule
